// File: rtl/wb_sram_slave.sv
// rtl/wb_sram_slave.sv - Wishbone B4 registered-feedback SRAM slave; optional ADR range check via WB_SRAM_SLAVE_RANGE_ERR_EN
module wb_sram_slave #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_WORDS     = 1024,
  parameter int WAIT_STATES   = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WB_ADDR_WIDTH-1:0]   ADR,
  input  logic [2:0]                 CTI,
  input  logic [1:0]                 BTE,
  input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
  output logic [WB_DATA_WIDTH-1:0]   DAT_R,
  input  logic                       CYC,
  input  logic                       STB,
  input  logic [WB_DATA_WIDTH/8-1:0] SEL,
  input  logic                       WE,
  output logic                       ACK,
  output logic                       ERR
);

  localparam int NB  = WB_DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int MW  = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE} state_t;

  state_t                   state;
  logic [MW-1:0]            addr_q;
  logic [MW-1:0]            addr_nxt;
  logic [MW-1:0]            adr_idx;
  logic [MW-1:0]            wrap_mask;
  logic [1:0]               bte_q;
  logic                     err_q;
  logic [1:0]               wait_cnt;
  logic                     range_err;
  logic                     beat;
  logic                     wr_beat;
  logic [WB_DATA_WIDTH-1:0] rd_fwd;
  logic                     unused_adr;
  logic [WB_DATA_WIDTH-1:0] mem [MEM_WORDS];

  assign adr_idx    = ADR[LSB +: MW];
  assign unused_adr = ^ADR;

`ifdef WB_SRAM_SLAVE_RANGE_ERR_EN
  // Any byte-address bit above the RAM window marks the transfer as out of range
  assign range_err = (ADR >> (LSB + MW)) != '0;
`else
  assign range_err = 1'b0;
`endif

  // A beat completes in ACTIVE whenever the master still holds CYC&STB; errored transfers never write
  assign beat    = (state == ACTIVE) && CYC && STB;
  assign wr_beat = beat && WE && !err_q && rstn;

  // Next burst address: wrap-N bursts only advance the low log2(N) bits
  always_comb begin
    wrap_mask = '1;
    case (bte_q)
      2'b01:   wrap_mask = MW'(3);
      2'b10:   wrap_mask = MW'(7);
      2'b11:   wrap_mask = MW'(15);
      default: wrap_mask = '1;
    endcase
    addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + MW'(1)) & wrap_mask);
  end

  // Prefetch of the next burst word, forwarding bytes written in this same beat
  always_comb begin
    rd_fwd = mem[addr_nxt];
    if (wr_beat && (addr_nxt == addr_q)) begin
      for (int i = 0; i < NB; i++) begin
        if (SEL[i]) rd_fwd[8*i +: 8] = DAT_W[8*i +: 8];
      end
    end
  end

  // Byte-lane RAM write on each accepted write beat
  always_ff @(posedge clk) begin
    if (wr_beat) begin
      for (int i = 0; i < NB; i++) begin
        if (SEL[i]) mem[addr_q][8*i +: 8] <= DAT_W[8*i +: 8];
      end
    end
  end

  // Transfer FSM with registered ACK/ERR/DAT_R
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      addr_q   <= '0;
      bte_q    <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
      ACK      <= 1'b0;
      ERR      <= 1'b0;
      DAT_R    <= '0;
    end else begin
      case (state)
        IDLE: begin
          ACK   <= 1'b0;
          ERR   <= 1'b0;
          DAT_R <= '0;
          if (CYC && STB) begin
            addr_q <= adr_idx;
            bte_q  <= BTE;
            err_q  <= range_err;
            if (WAIT_STATES > 0) begin
              state    <= WAIT;
              wait_cnt <= 2'(WAIT_STATES - 1);
            end else begin
              state <= ACTIVE;
              ACK   <= !range_err;
              ERR   <= range_err;
              DAT_R <= range_err ? '0 : mem[adr_idx];
            end
          end
        end
        WAIT: begin
          if (!(CYC && STB)) begin
            state <= IDLE;
          end else if (wait_cnt == 2'd0) begin
            state <= ACTIVE;
            ACK   <= !err_q;
            ERR   <= err_q;
            DAT_R <= err_q ? '0 : mem[addr_q];
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ACTIVE: begin
          if (beat && !err_q && (CTI == 3'b010)) begin
            addr_q <= addr_nxt;
            DAT_R  <= rd_fwd;
          end else begin
            state <= IDLE;
            ACK   <= 1'b0;
            ERR   <= 1'b0;
            DAT_R <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb/tb_wb_sram_slave.sv - randomized self-checking bench for wb_sram_slave against a word-array model
module tb_wb_sram_slave;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int WORDS = 1024;
  localparam int WS    = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] ADR;
  logic [2:0]    CTI;
  logic [1:0]    BTE;
  logic [DW-1:0] DAT_W;
  logic [DW-1:0] DAT_R;
  logic          CYC;
  logic          STB;
  logic [3:0]    SEL;
  logic          WE;
  logic          ACK;
  logic          ERR;

  always #5 clk = ~clk;

  wb_sram_slave #(
    .WB_ADDR_WIDTH(AW),
    .WB_DATA_WIDTH(DW),
    .MEM_WORDS(WORDS),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .ADR(ADR),
    .CTI(CTI),
    .BTE(BTE),
    .DAT_W(DAT_W),
    .DAT_R(DAT_R),
    .CYC(CYC),
    .STB(STB),
    .SEL(SEL),
    .WE(WE),
    .ACK(ACK),
    .ERR(ERR)
  );

  logic [31:0] model [WORDS];
  logic [31:0] wdata [WORDS];
  logic [2:0]  cti_classic [7];
  logic [31:0] last_rd;
  logic [31:0] saved_a;
  logic [31:0] saved_b;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Word touched by beat b of a burst starting at word 'start'
  function automatic int beat_word(input int start, input int b, input int bte);
    int n;
    n = (bte == 0) ? WORDS : (4 << (bte - 1));
    return (start - start % n) + (start % n + b) % n;
  endfunction

  // abort_kind: 0 none, 1 drop STB after abort_at beats, 2 assert reset during beat abort_at
  task automatic xfer(input logic [31:0] adr, input int len, input logic [1:0] bte,
                      input logic we, input logic [3:0] sel, input int abort_at, input int abort_kind);
    int start;
    int lat;
    int w;
    bit exp_err;
    start = int'((adr >> 2) % WORDS);
`ifdef WB_SRAM_SLAVE_RANGE_ERR_EN
    exp_err = (adr >> 12) != 0;
`else
    exp_err = 1'b0;
`endif
    @(posedge clk); #1;
    CYC = 1'b1; STB = 1'b1; ADR = adr; BTE = bte; WE = we; SEL = sel; DAT_W = wdata[0];
    CTI = (len == 1) ? cti_classic[$urandom_range(0, 6)] : 3'b010;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(ACK || ERR) && lat < 20);
    check("latency", 32'(lat), 32'(1 + WS));
    if (exp_err) begin
      check("err_resp", {30'd0, ACK, ERR}, 32'd1);
      @(posedge clk); #1;
      CYC = 1'b0; STB = 1'b0;
      @(negedge clk);
      check("err_one_cycle", {30'd0, ACK, ERR}, 32'd0);
      return;
    end
    check("ack_resp", {30'd0, ACK, ERR}, 32'd2);
    for (int b = 0; b < len; b++) begin
      w = beat_word(start, b, int'(bte));
      if (b > 0) check("ack_burst", {31'd0, ACK}, 32'd1);
      if (!we) begin
        check("rdata", DAT_R, model[w]);
        last_rd = DAT_R;
      end
      @(posedge clk);
      if (we) begin
        for (int i = 0; i < 4; i++) if (sel[i]) model[w][8*i +: 8] = wdata[b][8*i +: 8];
      end
      #1;
      if (abort_kind == 1 && abort_at == b + 1 && b + 1 < len) begin
        STB = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ack_after_stb_drop", {31'd0, ACK}, 32'd0);
        return;
      end
      if (abort_kind == 2 && abort_at == b + 1 && b + 1 < len) begin
        DAT_W = wdata[b+1];
        CTI = 3'b010;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1; CYC = 1'b0; STB = 1'b0;
        @(negedge clk);
        check("ack_after_reset", {31'd0, ACK}, 32'd0);
        check("dat_r_after_reset", DAT_R, 32'd0);
        return;
      end
      if (b + 1 < len) begin
        DAT_W = wdata[b+1];
        CTI = (b + 2 == len) ? 3'b111 : 3'b010;
      end else begin
        CYC = 1'b0; STB = 1'b0;
      end
      @(negedge clk);
    end
    check("ack_end", {30'd0, ACK, ERR}, 32'd0);
    check("dat_r_idle", DAT_R, 32'd0);
  endtask

  initial begin
    cti_classic[0] = 3'b000; cti_classic[1] = 3'b001; cti_classic[2] = 3'b011;
    cti_classic[3] = 3'b100; cti_classic[4] = 3'b101; cti_classic[5] = 3'b110;
    cti_classic[6] = 3'b111;
    rstn = 1'b0; CYC = 1'b0; STB = 1'b0; ADR = '0; CTI = '0; BTE = '0;
    DAT_W = '0; SEL = '0; WE = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'd0, ACK}, 32'd0);
    check("rst_err", {31'd0, ERR}, 32'd0);
    check("rst_dat_r", DAT_R, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Fill the whole RAM with one long linear write burst so every word is known
    for (int i = 0; i < WORDS; i++) wdata[i] = $urandom;
    xfer(32'h0, WORDS, 2'b00, 1'b1, 4'hF, 0, 0);

    // Classic write then read
    wdata[0] = 32'hA5A5_1234;
    xfer(32'h10, 1, 2'b00, 1'b1, 4'hF, 0, 0);
    xfer(32'h10, 1, 2'b00, 1'b0, 4'hF, 0, 0);
    check("classic_rd", last_rd, 32'hA5A5_1234);

    // Single byte lane write over a zero word
    wdata[0] = 32'h0;
    xfer(32'h20, 1, 2'b00, 1'b1, 4'hF, 0, 0);
    wdata[0] = 32'hFFFF_FFFF;
    xfer(32'h20, 1, 2'b00, 1'b1, 4'h2, 0, 0);
    xfer(32'h20, 1, 2'b00, 1'b0, 4'hF, 0, 0);
    check("sel_lane_rd", last_rd, 32'h0000_FF00);

    // Wrap4 read burst from word 6 returns words 6,7,4,5
    wdata[0] = 32'h44; wdata[1] = 32'h55; wdata[2] = 32'h66; wdata[3] = 32'h77;
    xfer(32'h10, 4, 2'b00, 1'b1, 4'hF, 0, 0);
    xfer(32'h18, 4, 2'b01, 1'b0, 4'hF, 0, 0);
    check("wrap4_last", last_rd, 32'h55);

    // Linear burst wrapping past the top of the RAM
    wdata[0] = 32'hDEAD_0001; wdata[1] = 32'hDEAD_0002;
    xfer(32'(4 * (WORDS - 1)), 2, 2'b00, 1'b1, 4'hF, 0, 0);
    xfer(32'(4 * (WORDS - 1)), 1, 2'b00, 1'b0, 4'hF, 0, 0);
    check("top_word", last_rd, 32'hDEAD_0001);
    xfer(32'h0, 1, 2'b00, 1'b0, 4'hF, 0, 0);
    check("wrapped_word0", last_rd, 32'hDEAD_0002);

    // STB dropped mid-burst, then a fresh transfer at 0x40
    xfer(32'h80, 8, 2'b00, 1'b0, 4'hF, 2, 1);
    xfer(32'h40, 1, 2'b00, 1'b0, 4'hF, 0, 0);
    check("restart_word10", last_rd, model[16]);

    // Out-of-range write: errored with the range check, aliased to word 0 without it
    saved_a = model[0];
    wdata[0] = 32'h1234_5678;
    xfer(32'h1000, 1, 2'b00, 1'b1, 4'hF, 0, 0);
    xfer(32'h0, 1, 2'b00, 1'b0, 4'hF, 0, 0);
`ifdef WB_SRAM_SLAVE_RANGE_ERR_EN
    check("range_word0", last_rd, saved_a);
`else
    check("alias_word0", last_rd, 32'h1234_5678);
`endif

    // Reset during beat 2 of a write burst: beats 0,1 persist, beat 2 is dropped
    saved_a = model[32'h82];
    for (int i = 0; i < 4; i++) wdata[i] = $urandom;
    saved_b = wdata[1];
    xfer(32'h200, 4, 2'b00, 1'b1, 4'hF, 2, 2);
    xfer(32'h208, 1, 2'b00, 1'b0, 4'hF, 0, 0);
    check("reset_no_write", last_rd, saved_a);
    xfer(32'h204, 1, 2'b00, 1'b0, 4'hF, 0, 0);
    check("reset_kept_write", last_rd, saved_b);

    // Random classic and burst traffic
    for (int t = 0; t < 60; t++) begin
      int          len;
      logic [31:0] adr;
      len = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 16);
      adr = $urandom_range(0, 4095) & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) adr = adr | 32'h0001_0000;
      for (int i = 0; i < 16; i++) wdata[i] = $urandom;
      xfer(adr, len, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
